calc_ctrl: RTL and testbench

CALC_CTRL -- requirements
Module: calc_ctrl

---
 rtl/calc_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_calc_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/calc_ctrl.sv
// Cursor-driven 4x4 keypad calculator: synchronised/edge-detected keys move a cursor,
// and "ok" feeds the selected cell into a small single-digit arithmetic FSM.
module calc_ctrl (
  input  logic        clk_in,
  input  logic        sys_rst,
  input  logic        key_up,
  input  logic        key_down,
  input  logic        key_left,
  input  logic        key_right,
  input  logic        key_ok,
  output logic [3:0]  cursor_x,
  output logic [3:0]  cursor_y,
  output logic [7:0]  input_val,
  output logic [7:0]  op_char,
  output logic [15:0] result,
  output logic        calc_done
);

  typedef enum logic [2:0] {S_IDLE, S_A, S_OP, S_B, S_DONE} state_t;
  typedef enum logic [2:0] {K_NONE, K_DIGIT, K_OP, K_CLR, K_EQ} kind_t;

  // Key vector order: ok, up, down, left, right (bit 4 has the highest priority)
  logic [4:0]  keys_s;
  logic [4:0]  sync1_r, sync2_r, prev_r, armed_r, rise_s;
  logic [1:0]  fill_r;
  state_t      state_r, state_s;
  kind_t       kind_s;
  logic [3:0]  a_r, a_s, b_r, b_s, digit_s;
  logic [7:0]  opc_s;
  logic [3:0]  cursor_x_s, cursor_y_s;
  logic [7:0]  input_val_s, op_char_s;
  logic [15:0] result_s;
  logic        calc_done_s;

  function automatic logic [15:0] calc_fn(input logic [3:0] a, input logic [3:0] b,
                                          input logic [7:0] op);
    logic [15:0] a16;
    logic [15:0] b16;
    logic [15:0] r;
    a16 = {12'd0, a};
    b16 = {12'd0, b};
    case (op)
      8'h2B:   r = a16 + b16;
      8'h2D:   r = (a >= b) ? (a16 - b16) : 16'd0;
      8'h2A:   r = a16 * b16;
      default: r = 16'd0;
    endcase
    return r;
  endfunction

  assign keys_s = {key_ok, key_up, key_down, key_left, key_right};
  // A key only arms once it has been seen released after the chain refilled post-reset,
  // so a key held across reset release cannot fire.
  assign rise_s = sync2_r & ~prev_r & armed_r;

  // Key synchronisers, edge-detect history and arming
  always_ff @(posedge clk_in or posedge sys_rst) begin
    if (sys_rst) begin
      sync1_r <= 5'd0;
      sync2_r <= 5'd0;
      prev_r  <= 5'd0;
      armed_r <= 5'd0;
      fill_r  <= 2'd0;
    end else begin
      sync1_r <= keys_s;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
      if (fill_r != 2'd2) begin
        fill_r <= fill_r + 2'd1;
      end else begin
        armed_r <= armed_r | ~sync2_r;
      end
    end
  end

  // Decode the cell under the cursor
  always_comb begin
    kind_s  = K_NONE;
    digit_s = 4'd0;
    opc_s   = 8'h00;
    case ({cursor_y, cursor_x})
      8'h00:   begin kind_s = K_DIGIT; digit_s = 4'd1; end
      8'h01:   begin kind_s = K_DIGIT; digit_s = 4'd2; end
      8'h02:   begin kind_s = K_DIGIT; digit_s = 4'd3; end
      8'h03:   begin kind_s = K_OP;    opc_s   = 8'h2B; end
      8'h10:   begin kind_s = K_DIGIT; digit_s = 4'd4; end
      8'h11:   begin kind_s = K_DIGIT; digit_s = 4'd5; end
      8'h12:   begin kind_s = K_DIGIT; digit_s = 4'd6; end
      8'h13:   begin kind_s = K_OP;    opc_s   = 8'h2D; end
      8'h20:   begin kind_s = K_DIGIT; digit_s = 4'd7; end
      8'h21:   begin kind_s = K_DIGIT; digit_s = 4'd8; end
      8'h22:   begin kind_s = K_DIGIT; digit_s = 4'd9; end
      8'h23:   begin kind_s = K_OP;    opc_s   = 8'h2A; end
      8'h30:   kind_s = K_CLR;
      8'h31:   begin kind_s = K_DIGIT; digit_s = 4'd0; end
      8'h32:   kind_s = K_EQ;
      default: kind_s = K_NONE;
    endcase
  end

  // Next-state: at most one action per cycle, ok > up > down > left > right
  always_comb begin
    state_s     = state_r;
    a_s         = a_r;
    b_s         = b_r;
    cursor_x_s  = cursor_x;
    cursor_y_s  = cursor_y;
    input_val_s = input_val;
    op_char_s   = op_char;
    result_s    = result;
    calc_done_s = calc_done;
    if (rise_s[4]) begin
      case (kind_s)
        K_CLR: begin
          state_s     = S_IDLE;
          a_s         = 4'd0;
          b_s         = 4'd0;
          input_val_s = 8'h00;
          op_char_s   = 8'h00;
          result_s    = 16'd0;
          calc_done_s = 1'b0;
        end
        K_DIGIT: begin
          case (state_r)
            S_IDLE, S_A: begin
              a_s         = digit_s;
              input_val_s = 8'h30 + {4'd0, digit_s};
              state_s     = S_A;
            end
            S_OP, S_B: begin
              b_s         = digit_s;
              input_val_s = 8'h30 + {4'd0, digit_s};
              state_s     = S_B;
            end
            S_DONE: begin
              a_s         = digit_s;
              input_val_s = 8'h30 + {4'd0, digit_s};
              op_char_s   = 8'h00;
              result_s    = 16'd0;
              calc_done_s = 1'b0;
              state_s     = S_A;
            end
            default: state_s = state_r;
          endcase
        end
        K_OP: begin
          case (state_r)
            S_A: begin
              op_char_s = opc_s;
              state_s   = S_OP;
            end
            S_OP, S_B: op_char_s = opc_s;
            default:   state_s = state_r;
          endcase
        end
        K_EQ: begin
          if (state_r == S_B) begin
            result_s    = calc_fn(a_r, b_r, op_char);
            calc_done_s = 1'b1;
            state_s     = S_DONE;
          end else begin
            state_s = state_r;
          end
        end
        default: state_s = state_r;
      endcase
    end else if (rise_s[3]) begin
      cursor_y_s = (cursor_y == 4'd0) ? 4'd3 : cursor_y - 4'd1;
    end else if (rise_s[2]) begin
      cursor_y_s = (cursor_y == 4'd3) ? 4'd0 : cursor_y + 4'd1;
    end else if (rise_s[1]) begin
      cursor_x_s = (cursor_x == 4'd0) ? 4'd3 : cursor_x - 4'd1;
    end else if (rise_s[0]) begin
      cursor_x_s = (cursor_x == 4'd3) ? 4'd0 : cursor_x + 4'd1;
    end else begin
      state_s = state_r;
    end
  end

  // State, operand and output registers
  always_ff @(posedge clk_in or posedge sys_rst) begin
    if (sys_rst) begin
      state_r   <= S_IDLE;
      a_r       <= 4'd0;
      b_r       <= 4'd0;
      cursor_x  <= 4'd0;
      cursor_y  <= 4'd0;
      input_val <= 8'h00;
      op_char   <= 8'h00;
      result    <= 16'd0;
      calc_done <= 1'b0;
    end else begin
      state_r   <= state_s;
      a_r       <= a_s;
      b_r       <= b_s;
      cursor_x  <= cursor_x_s;
      cursor_y  <= cursor_y_s;
      input_val <= input_val_s;
      op_char   <= op_char_s;
      result    <= result_s;
      calc_done <= calc_done_s;
    end
  end

endmodule

// File: tb/tb_calc_ctrl.sv
// Directed bench for calc_ctrl: a table of key presses with hand-computed outputs,
// then hand-written sequences for latency, priority, hold and reset corner cases.
module tb_calc_ctrl;

  localparam logic [2:0] KR = 3'd0;
  localparam logic [2:0] KL = 3'd1;
  localparam logic [2:0] KD = 3'd2;
  localparam logic [2:0] KU = 3'd3;
  localparam logic [2:0] KO = 3'd4;

  typedef struct {
    logic [2:0]  key;
    logic [3:0]  cx;
    logic [3:0]  cy;
    logic [7:0]  iv;
    logic [7:0]  op;
    logic [15:0] res;
    logic        done;
  } vec_t;

  logic        clk_in = 1'b0;
  logic        sys_rst;
  logic        key_up, key_down, key_left, key_right, key_ok;
  logic [3:0]  cursor_x, cursor_y;
  logic [7:0]  input_val, op_char;
  logic [15:0] result;
  logic        calc_done;

  int checks = 0;
  int failures = 0;
  vec_t vq[$];

  calc_ctrl dut (
    .clk_in(clk_in), .sys_rst(sys_rst),
    .key_up(key_up), .key_down(key_down), .key_left(key_left),
    .key_right(key_right), .key_ok(key_ok),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .input_val(input_val),
    .op_char(op_char), .result(result), .calc_done(calc_done)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int cx, input int cy, input int iv,
                         input int op, input int res, input int done);
    chk({tag, ".cursor_x"},  16'(cursor_x),  16'(cx));
    chk({tag, ".cursor_y"},  16'(cursor_y),  16'(cy));
    chk({tag, ".input_val"}, 16'(input_val), 16'(iv));
    chk({tag, ".op_char"},   16'(op_char),   16'(op));
    chk({tag, ".result"},    result,         16'(res));
    chk({tag, ".calc_done"}, 16'(calc_done), 16'(done));
  endtask

  task automatic set_key(input logic [2:0] k, input logic v);
    case (k)
      KR:      key_right = v;
      KL:      key_left  = v;
      KD:      key_down  = v;
      KU:      key_up    = v;
      KO:      key_ok    = v;
      default: key_ok    = key_ok;
    endcase
  endtask

  // Called at a falling edge; leaves the bench at a falling edge with the action settled
  task automatic press(input logic [2:0] k);
    set_key(k, 1'b1);
    repeat (2) @(negedge clk_in);
    set_key(k, 1'b0);
    repeat (4) @(negedge clk_in);
  endtask

  task automatic add(input logic [2:0] k, input int cx, input int cy, input int iv,
                     input int op, input int res, input int done);
    vec_t v;
    v.key = k; v.cx = 4'(cx); v.cy = 4'(cy); v.iv = 8'(iv);
    v.op = 8'(op); v.res = 16'(res); v.done = 1'(done);
    vq.push_back(v);
  endtask

  initial begin
    key_up = 1'b0; key_down = 1'b0; key_left = 1'b0; key_right = 1'b0; key_ok = 1'b0;
    sys_rst = 1'b1;
    repeat (3) @(negedge clk_in);
    chk_all("in_reset", 0, 0, 0, 0, 0, 0);
    sys_rst = 1'b0;
    repeat (5) @(negedge clk_in);
    chk_all("idle", 0, 0, 0, 0, 0, 0);

    // Wrap-around moves, then 7*8=
    add(KR,1,0,8'h00,8'h00,0,0);  add(KR,2,0,8'h00,8'h00,0,0);  add(KR,3,0,8'h00,8'h00,0,0);
    add(KR,0,0,8'h00,8'h00,0,0);  add(KR,1,0,8'h00,8'h00,0,0);  add(KU,1,3,8'h00,8'h00,0,0);
    add(KL,0,3,8'h00,8'h00,0,0);  add(KU,0,2,8'h00,8'h00,0,0);  add(KO,0,2,8'h37,8'h00,0,0);
    add(KD,0,3,8'h37,8'h00,0,0);  add(KR,1,3,8'h37,8'h00,0,0);  add(KR,2,3,8'h37,8'h00,0,0);
    add(KO,2,3,8'h37,8'h00,0,0);  add(KU,2,2,8'h37,8'h00,0,0);  add(KR,3,2,8'h37,8'h00,0,0);
    add(KO,3,2,8'h37,8'h2A,0,0);  add(KL,2,2,8'h37,8'h2A,0,0);  add(KL,1,2,8'h37,8'h2A,0,0);
    add(KO,1,2,8'h38,8'h2A,0,0);  add(KD,1,3,8'h38,8'h2A,0,0);  add(KR,2,3,8'h38,8'h2A,0,0);
    add(KO,2,3,8'h38,8'h2A,56,1);
    // 3-5= saturates, then 4 restarts from S_DONE
    add(KU,2,2,8'h38,8'h2A,56,1); add(KU,2,1,8'h38,8'h2A,56,1); add(KU,2,0,8'h38,8'h2A,56,1);
    add(KO,2,0,8'h33,8'h00,0,0);  add(KR,3,0,8'h33,8'h00,0,0);  add(KD,3,1,8'h33,8'h00,0,0);
    add(KO,3,1,8'h33,8'h2D,0,0);  add(KL,2,1,8'h33,8'h2D,0,0);  add(KL,1,1,8'h33,8'h2D,0,0);
    add(KO,1,1,8'h35,8'h2D,0,0);  add(KD,1,2,8'h35,8'h2D,0,0);  add(KD,1,3,8'h35,8'h2D,0,0);
    add(KR,2,3,8'h35,8'h2D,0,0);  add(KO,2,3,8'h35,8'h2D,0,1);  add(KU,2,2,8'h35,8'h2D,0,1);
    add(KU,2,1,8'h35,8'h2D,0,1);  add(KL,1,1,8'h35,8'h2D,0,1);  add(KL,0,1,8'h35,8'h2D,0,1);
    add(KO,0,1,8'h34,8'h00,0,0);
    // Blank cell, then "+",1 and C in S_B, then "+" ignored in S_IDLE
    add(KL,3,1,8'h34,8'h00,0,0);  add(KD,3,2,8'h34,8'h00,0,0);  add(KD,3,3,8'h34,8'h00,0,0);
    add(KO,3,3,8'h34,8'h00,0,0);  add(KD,3,0,8'h34,8'h00,0,0);  add(KO,3,0,8'h34,8'h2B,0,0);
    add(KR,0,0,8'h34,8'h2B,0,0);  add(KO,0,0,8'h31,8'h2B,0,0);  add(KU,0,3,8'h31,8'h2B,0,0);
    add(KO,0,3,8'h00,8'h00,0,0);  add(KD,0,0,8'h00,8'h00,0,0);  add(KL,3,0,8'h00,8'h00,0,0);
    add(KO,3,0,8'h00,8'h00,0,0);
    // 9-2=7, "=" ignored in S_DONE
    add(KD,3,1,8'h00,8'h00,0,0);  add(KD,3,2,8'h00,8'h00,0,0);  add(KL,2,2,8'h00,8'h00,0,0);
    add(KO,2,2,8'h39,8'h00,0,0);  add(KR,3,2,8'h39,8'h00,0,0);  add(KU,3,1,8'h39,8'h00,0,0);
    add(KO,3,1,8'h39,8'h2D,0,0);  add(KU,3,0,8'h39,8'h2D,0,0);  add(KL,2,0,8'h39,8'h2D,0,0);
    add(KL,1,0,8'h39,8'h2D,0,0);  add(KO,1,0,8'h32,8'h2D,0,0);  add(KU,1,3,8'h32,8'h2D,0,0);
    add(KR,2,3,8'h32,8'h2D,0,0);  add(KO,2,3,8'h32,8'h2D,7,1);  add(KO,2,3,8'h32,8'h2D,7,1);
    // 5*9 with operator replaced by "+" in S_B: 14
    add(KU,2,2,8'h32,8'h2D,7,1);  add(KU,2,1,8'h32,8'h2D,7,1);  add(KL,1,1,8'h32,8'h2D,7,1);
    add(KO,1,1,8'h35,8'h00,0,0);  add(KR,2,1,8'h35,8'h00,0,0);  add(KR,3,1,8'h35,8'h00,0,0);
    add(KD,3,2,8'h35,8'h00,0,0);  add(KO,3,2,8'h35,8'h2A,0,0);  add(KL,2,2,8'h35,8'h2A,0,0);
    add(KO,2,2,8'h39,8'h2A,0,0);  add(KR,3,2,8'h39,8'h2A,0,0);  add(KU,3,1,8'h39,8'h2A,0,0);
    add(KU,3,0,8'h39,8'h2A,0,0);  add(KO,3,0,8'h39,8'h2B,0,0);  add(KL,2,0,8'h39,8'h2B,0,0);
    add(KU,2,3,8'h39,8'h2B,0,0);  add(KO,2,3,8'h39,8'h2B,14,1);

    foreach (vq[i]) begin
      press(vq[i].key);
      chk_all($sformatf("vec%0d", i), int'(vq[i].cx), int'(vq[i].cy), int'(vq[i].iv),
              int'(vq[i].op), int'(vq[i].res), int'(vq[i].done));
    end

    // 0+5 with the "=" latency measured edge by edge
    press(KL); press(KO); press(KR); press(KR); press(KD); press(KO);
    press(KL); press(KL); press(KD); press(KO); press(KD); press(KD); press(KR);
    chk_all("pre_eq", 2, 3, 8'h35, 8'h2B, 0, 0);
    key_ok = 1'b1;
    @(negedge clk_in);
    chk("eq_lat_k", result, 16'd0);
    @(negedge clk_in);
    chk("eq_lat_k1", 16'(calc_done), 16'd0);
    @(negedge clk_in);
    chk("eq_lat_k2_res", result, 16'd5);
    chk("eq_lat_k2_done", 16'(calc_done), 16'd1);
    key_ok = 1'b0;
    repeat (4) @(negedge clk_in);

    // ok and right together: only ok acts ("0" in S_DONE)
    press(KL);
    key_ok = 1'b1; key_right = 1'b1;
    repeat (2) @(negedge clk_in);
    key_ok = 1'b0; key_right = 1'b0;
    repeat (4) @(negedge clk_in);
    chk_all("ok_right", 1, 3, 8'h30, 8'h00, 0, 0);

    // Long hold produces one move
    key_down = 1'b1;
    repeat (100) @(negedge clk_in);
    chk_all("hold", 1, 0, 8'h30, 8'h00, 0, 0);
    key_down = 1'b0;
    repeat (4) @(negedge clk_in);
    chk_all("hold_rel", 1, 0, 8'h30, 8'h00, 0, 0);

    // Asynchronous reset mid-calculation, with ok held across release
    press(KO);
    chk_all("pre_rst", 1, 0, 8'h32, 8'h00, 0, 0);
    #2 sys_rst = 1'b1;
    key_ok = 1'b1;
    #1 chk_all("async_rst", 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk_in);
    sys_rst = 1'b0;
    repeat (10) @(negedge clk_in);
    chk_all("held_over_rst", 0, 0, 0, 0, 0, 0);
    key_ok = 1'b0;
    repeat (4) @(negedge clk_in);
    press(KO);
    chk_all("repress", 0, 0, 8'h31, 8'h00, 0, 0);

    // Cursor move latency: visible only after the third edge
    key_right = 1'b1;
    @(negedge clk_in);
    chk("mv_lat_k", 16'(cursor_x), 16'd0);
    @(negedge clk_in);
    chk("mv_lat_k1", 16'(cursor_x), 16'd0);
    @(negedge clk_in);
    chk("mv_lat_k2", 16'(cursor_x), 16'd1);
    key_right = 1'b0;
    repeat (4) @(negedge clk_in);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
